// File: rtl/ads1292_filter_pkg.sv
// rtl/ads1292_filter_pkg.sv - shared types, defaults and saturation helper for the ADS1292 filter chain
package ads1292_filter_pkg;

  localparam int DEF_IN_W  = 24;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_K     = 8;
  localparam int DEF_FRAC  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Clamp a sign-extended 64-bit value into the signed range of a w-bit word.
  // The caller slices the low w bits; for w <= 63 the result always fits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_signed = hi;
    end else if (v < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = v;
    end
  endfunction

endpackage

// File: rtl/ads1292_dc_blocker_if.sv
// rtl/ads1292_dc_blocker_if.sv - strobe/acknowledge sample ports of the DC blocker
interface ads1292_dc_blocker_if
  import ads1292_filter_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic signed [IN_W-1:0]  input_a;
  logic                    input_a_stb;
  logic                    input_a_ack;
  logic signed [OUT_W-1:0] output_z;
  logic                    output_z_stb;
  logic                    output_z_ack;

  // Upstream source / downstream sink side
  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  // Filter block side
  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );

endinterface

// File: rtl/dc_blocker_datapath.sv
// rtl/dc_blocker_datapath.sv - combinational difference, leaky feedback and clamping
module dc_blocker_datapath
  import ads1292_filter_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int K     = DEF_K,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [IN_W-1:0]       i_x,
  input  logic signed [IN_W-1:0]       i_x_prev,
  input  logic signed [OUT_W+FRAC-1:0] i_acc,
  input  logic                         i_primed,
  output logic signed [OUT_W+FRAC-1:0] o_acc_next,
  output logic signed [OUT_W-1:0]      o_z_next,
  output logic                         o_sat
);

  localparam int ACC_W = OUT_W + FRAC;
  // Two guard bits hold the sum of a full-scale difference and the accumulator
  localparam int T_W   = ACC_W + 2;

  logic signed [T_W-1:0]   w_x_ext;
  logic signed [T_W-1:0]   w_xp_ext;
  logic signed [T_W-1:0]   w_acc_ext;
  logic signed [T_W-1:0]   w_d;
  logic signed [T_W-1:0]   w_t;
  logic signed [63:0]      w_t64;
  logic signed [63:0]      w_t_sat;
  logic signed [ACC_W-1:0] w_acc_new;
  logic signed [ACC_W-1:0] w_sh;
  logic signed [63:0]      w_sh64;
  logic signed [63:0]      w_z_sat;
  logic                    w_clamp_acc;
  logic                    w_clamp_z;

  assign w_x_ext   = {{(T_W-IN_W){i_x[IN_W-1]}}, i_x};
  assign w_xp_ext  = {{(T_W-IN_W){i_x_prev[IN_W-1]}}, i_x_prev};
  assign w_acc_ext = {{(T_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
  assign w_d       = w_x_ext - w_xp_ext;

  // acc*(1 - 2^-K) is formed as acc - (acc >>> K); arithmetic shifts floor toward -inf
  assign w_t = (w_d <<< FRAC) + w_acc_ext - (w_acc_ext >>> K);

  assign w_t64       = {{(64-T_W){w_t[T_W-1]}}, w_t};
  assign w_t_sat     = sat_signed(w_t64, ACC_W);
  assign w_clamp_acc = (w_t_sat != w_t64);
  assign w_acc_new   = w_t_sat[ACC_W-1:0];

  assign w_sh      = w_acc_new >>> FRAC;
  assign w_sh64    = {{(64-ACC_W){w_sh[ACC_W-1]}}, w_sh};
  assign w_z_sat   = sat_signed(w_sh64, OUT_W);
  assign w_clamp_z = (w_z_sat != w_sh64);

  // The priming sample only seeds x_prev, so it must produce a zero result
  assign o_acc_next = i_primed ? w_acc_new : '0;
  assign o_z_next   = i_primed ? w_z_sat[OUT_W-1:0] : '0;
  assign o_sat      = i_primed & (w_clamp_acc | w_clamp_z);

endmodule

// File: rtl/ads1292_dc_blocker.sv
// rtl/ads1292_dc_blocker.sv - single-pole DC-blocking high-pass stage with strobe/ack ports
module ads1292_dc_blocker
  import ads1292_filter_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int K     = DEF_K,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                 clk,
  input  logic                 rstn,
  ads1292_dc_blocker_if.slave  bus,
  output logic                 sat_flag
);

  localparam int ACC_W = OUT_W + FRAC;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_live;
  logic signed [IN_W-1:0]  r_x;
  logic signed [IN_W-1:0]  r_x_prev;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_primed;
  logic signed [OUT_W-1:0] r_z;
  logic                    r_sat;

  logic                    w_ack;
  logic                    w_stb;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [OUT_W-1:0] w_z_next;
  logic                    w_sat;

  dc_blocker_datapath #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .K     (K),
    .FRAC  (FRAC)
  ) u_datapath (
    .i_x        (r_x),
    .i_x_prev   (r_x_prev),
    .i_acc      (r_acc),
    .i_primed   (r_primed),
    .o_acc_next (w_acc_next),
    .o_z_next   (w_z_next),
    .o_sat      (w_sat)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs; ack is held low until the first clock after reset
  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_stb        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ack = r_live;
        if (r_live && bus.input_a_stb) begin
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_stb = 1'b1;
        if (bus.output_z_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Marks that at least one clock has passed since reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Capture the incoming sample on an input transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x <= '0;
    end else if (w_ack && bus.input_a_stb) begin
      r_x <= bus.input_a;
    end
  end

  // Commit filter state and the registered result in CALC; reset discards any in-flight sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x_prev <= '0;
      r_acc    <= '0;
      r_primed <= 1'b0;
      r_z      <= '0;
      r_sat    <= 1'b0;
    end else if (r_state == ST_CALC) begin
      r_x_prev <= r_x;
      r_acc    <= w_acc_next;
      r_primed <= 1'b1;
      r_z      <= w_z_next;
      r_sat    <= r_sat | w_sat;
    end
  end

  assign bus.input_a_ack  = w_ack;
  assign bus.output_z_stb = w_stb;
  assign bus.output_z     = r_z;
  assign sat_flag         = r_sat;

endmodule

// File: tb/tb_ads1292_dc_blocker.sv
// tb/tb_ads1292_dc_blocker.sv - directed self-checking bench for ads1292_dc_blocker
module tb_ads1292_dc_blocker;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sat0;
  logic sat1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ads1292_dc_blocker_if #(.IN_W(24), .OUT_W(32)) bus0 ();
  ads1292_dc_blocker_if #(.IN_W(24), .OUT_W(24)) bus1 ();

  ads1292_dc_blocker #(.IN_W(24), .OUT_W(32), .K(8), .FRAC(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus0),
    .sat_flag (sat0)
  );

  ads1292_dc_blocker #(.IN_W(24), .OUT_W(24), .K(8), .FRAC(8)) dut_s (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus1),
    .sat_flag (sat1)
  );

  task automatic clear_inputs();
    bus0.input_a      = '0;
    bus0.input_a_stb  = 1'b0;
    bus0.output_z_ack = 1'b0;
    bus1.input_a      = '0;
    bus1.input_a_stb  = 1'b0;
    bus1.output_z_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One full input transfer, then wait for and accept the matching output
  task automatic run_sample(input bit s, input int x, output logic signed [31:0] z, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    if (s) begin bus1.input_a = x[23:0]; bus1.input_a_stb = 1'b1; end
    else begin bus0.input_a = x[23:0]; bus0.input_a_stb = 1'b1; end
    n = 0;
    while (((s ? bus1.input_a_ack : bus0.input_a_ack) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) ok = 1'b0;
    @(posedge clk);
    #1;
    bus0.input_a_stb = 1'b0;
    bus1.input_a_stb = 1'b0;
    n = 0;
    while (((s ? bus1.output_z_stb : bus0.output_z_stb) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) ok = 1'b0;
    z = s ? {{8{bus1.output_z[23]}}, bus1.output_z} : bus0.output_z;
    if (s) bus1.output_z_ack = 1'b1; else bus0.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    bus0.output_z_ack = 1'b0;
    bus1.output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus0.input_a_ack !== 1'b0) $display("FAIL reset_ack: got %b, expected 0", bus0.input_a_ack); else n_pass++;
    n_checks++; if (bus0.output_z_stb !== 1'b0) $display("FAIL reset_stb: got %b, expected 0", bus0.output_z_stb); else n_pass++;
    n_checks++; if (bus0.output_z !== 32'sd0) $display("FAIL reset_z: got %0d, expected 0", bus0.output_z); else n_pass++;
    n_checks++; if (sat0 !== 1'b0) $display("FAIL reset_sat: got %b, expected 0", sat0); else n_pass++;
    n_checks++; if (bus1.input_a_ack !== 1'b0) $display("FAIL reset_ack_s: got %b, expected 0", bus1.input_a_ack); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (bus0.input_a_ack !== 1'b1) $display("FAIL post_reset_ack: got %b, expected 1", bus0.input_a_ack); else n_pass++;
  endtask

  task automatic test_priming();
    logic signed [31:0] z;
    bit ok;
    do_reset();
    run_sample(1'b0, 5000, z, ok);
    n_checks++; if (!ok || z !== 32'sd0) $display("FAIL prime_z: got %0d (handshake %0b), expected 0", z, ok); else n_pass++;
    n_checks++; if (sat0 !== 1'b0) $display("FAIL prime_sat: got %b, expected 0", sat0); else n_pass++;
  endtask

  task automatic test_step();
    int xs[4] = '{0, 1000, 1000, 1000};
    int ex[4] = '{0, 1000, 996, 992};
    logic signed [31:0] z;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_sample(1'b0, xs[i], z, ok);
      n_checks++; if (!ok || z !== ex[i]) $display("FAIL step[%0d]: got %0d (handshake %0b), expected %0d", i, z, ok, ex[i]); else n_pass++;
    end
    n_checks++; if (sat0 !== 1'b0) $display("FAIL step_sat: got %b, expected 0", sat0); else n_pass++;
  endtask

  task automatic test_neg_step();
    int xs[3] = '{0, -1000, -1000};
    int ex[3] = '{0, -1000, -997};
    logic signed [31:0] z;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_sample(1'b0, xs[i], z, ok);
      n_checks++; if (!ok || z !== ex[i]) $display("FAIL neg_step[%0d]: got %0d (handshake %0b), expected %0d", i, z, ok, ex[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] z;
    bit ok;
    bit bad;
    int n;
    do_reset();
    run_sample(1'b0, 0, z, ok);
    n_checks++; if (!ok || z !== 32'sd0) $display("FAIL bp_prime: got %0d (handshake %0b), expected 0", z, ok); else n_pass++;
    @(negedge clk);
    bus0.input_a = 24'sd1000;
    bus0.input_a_stb = 1'b1;
    n = 0;
    while (bus0.input_a_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus0.input_a = 24'sd500;
    while (bus0.output_z_stb !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++; if (n >= 40 || bus0.output_z !== 32'sd1000) $display("FAIL bp_first_z: got %0d (waited %0d), expected 1000", bus0.output_z, n); else n_pass++;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus0.output_z !== 32'sd1000 || bus0.input_a_ack !== 1'b0 || bus0.output_z_stb !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL bp_hold: got unstable=%b, expected 0", bad); else n_pass++;
    bus0.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    bus0.output_z_ack = 1'b0;
    n = 0;
    while (bus0.input_a_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus0.input_a_stb = 1'b0;
    while (bus0.output_z_stb !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++; if (n >= 40 || bus0.output_z !== 32'sd496) $display("FAIL bp_pending_z: got %0d (waited %0d), expected 496", bus0.output_z, n); else n_pass++;
    bus0.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    bus0.output_z_ack = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus0.output_z_stb !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL bp_no_duplicate: got extra_stb=%b, expected 0", bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int xs[4] = '{0, 1000, 1000, 1000};
    int ex[4] = '{0, 1000, 996, 992};
    int acc_cyc[4];
    logic signed [31:0] outs[4];
    int ni;
    int no;
    int cyc;
    bit take_in;
    do_reset();
    ni = 0; no = 0; cyc = 0;
    bus0.output_z_ack = 1'b1;
    bus0.input_a = xs[0][23:0];
    bus0.input_a_stb = 1'b1;
    while ((ni < 4 || no < 4) && cyc < 60) begin
      take_in = (bus0.input_a_ack === 1'b1 && bus0.input_a_stb === 1'b1);
      if (take_in) acc_cyc[ni] = cyc;
      if (bus0.output_z_stb === 1'b1 && no < 4) begin
        outs[no] = bus0.output_z;
        no++;
      end
      @(posedge clk);
      #1;
      if (take_in) begin
        ni++;
        if (ni < 4) bus0.input_a = xs[ni][23:0];
        else bus0.input_a_stb = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus0.output_z_ack = 1'b0;
    bus0.input_a_stb = 1'b0;
    n_checks++; if (ni != 4 || no != 4) $display("FAIL b2b_done: got in=%0d out=%0d, expected 4/4", ni, no); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (outs[i] !== ex[i]) $display("FAIL b2b_z[%0d]: got %0d, expected %0d", i, outs[i], ex[i]); else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != 3) $display("FAIL b2b_period[%0d]: got %0d, expected 3", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int xs[3] = '{0, 8388607, -8388608};
    int ex[3] = '{0, 8388607, -8388608};
    logic signed [31:0] z;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_sample(1'b1, xs[i], z, ok);
      n_checks++; if (!ok || z !== ex[i]) $display("FAIL sat_z[%0d]: got %0d (handshake %0b), expected %0d", i, z, ok, ex[i]); else n_pass++;
      if (i == 1) begin
        n_checks++; if (sat1 !== 1'b0) $display("FAIL sat_flag_early: got %b, expected 0", sat1); else n_pass++;
      end
    end
    n_checks++; if (sat1 !== 1'b1) $display("FAIL sat_flag: got %b, expected 1", sat1); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (sat1 !== 1'b1) $display("FAIL sat_flag_sticky: got %b, expected 1", sat1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic signed [31:0] z;
    bit ok;
    int n;
    do_reset();
    run_sample(1'b0, 100, z, ok);
    n_checks++; if (!ok || z !== 32'sd0) $display("FAIL mid_prime: got %0d (handshake %0b), expected 0", z, ok); else n_pass++;
    @(negedge clk);
    bus0.input_a = 24'sd200;
    bus0.input_a_stb = 1'b1;
    n = 0;
    while (bus0.input_a_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus0.input_a_stb = 1'b0;
    while (bus0.output_z_stb !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++; if (bus0.output_z_stb !== 1'b1) $display("FAIL mid_in_send: got stb=%b, expected 1", bus0.output_z_stb); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (bus0.output_z_stb !== 1'b0) $display("FAIL mid_stb_drop: got %b, expected 0", bus0.output_z_stb); else n_pass++;
    n_checks++; if (bus0.input_a_ack !== 1'b0) $display("FAIL mid_ack_drop: got %b, expected 0", bus0.input_a_ack); else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_sample(1'b0, 7, z, ok);
    n_checks++; if (!ok || z !== 32'sd0) $display("FAIL mid_after_0: got %0d (handshake %0b), expected 0", z, ok); else n_pass++;
    run_sample(1'b0, 9, z, ok);
    n_checks++; if (!ok || z !== 32'sd2) $display("FAIL mid_after_1: got %0d (handshake %0b), expected 2", z, ok); else n_pass++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_priming();
    test_step();
    test_neg_step();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
